cfg_stream_loader: RTL and testbench

CFG_STREAM_LOADER -- requirements
Module: cfg_stream_loader

---
 rtl/pe_types.sv | 17 +
 rtl/cfg_loader_buf.sv | 25 ++
 rtl/cfg_stream_loader.sv | 114 +++++++++++
 tb/tb_cfg_stream_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_types.sv
// Shared packet, cluster port and loader state types for the PE cluster and its config loader.
package pe_types;

  typedef struct packed {
    logic [7:0]  addr;
    logic [23:0] data;
  } packet_t;

  typedef enum logic [2:0] {SR, SL, WR, WL, NR, NL, EL, ER} cluster_port_t;

  typedef enum logic [1:0] {
    CL_IDLE   = 2'd0,
    CL_STREAM = 2'd1,
    CL_DONE   = 2'd2
  } cfg_loader_state_t;

endpackage

// File: rtl/cfg_loader_buf.sv
// Packet buffer: DEPTH x packet_t flops, one synchronous write port, one combinational read port.
module cfg_loader_buf
  import pe_types::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  packet_t       wdata,
  input  logic [AW-1:0] raddr,
  output packet_t       rdata
);

  // No reset: contents are only meaningful below wr_ptr, which resets to 0.
  packet_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cfg_stream_loader.sv
// Buffers host config packets, then streams the first N of them to one cluster ingress port.
// Optional stall counter output enabled by defining CFG_LOADER_PERF_EN.
module cfg_stream_loader
  import pe_types::*;
#(
  parameter int DEPTH = 64,
  parameter int SIDES = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  packet_t          load_data,
  output logic             load_ready,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       start_port,
  input  logic [CW-1:0]    start_count,
  output logic [SIDES-1:0] ing_enq,
  output packet_t          ing_wdata,
  input  logic [SIDES-1:0] ing_full,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef CFG_LOADER_PERF_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  cfg_loader_state_t state;
  logic [CW-1:0]     wr_ptr, rd_ptr, cnt;
  logic [2:0]        port_q;
  logic              rst_done;
  logic [SIDES-1:0]  port_mask;
  logic              stream, full_sel, enq, last, start_ok, wr_en;
  packet_t           rd_pkt;

  always_comb begin
    port_mask = '0;
    for (int i = 0; i < SIDES; i++) port_mask[i] = (port_q == 3'(i));
  end

  assign stream   = (state == CL_STREAM);
  assign full_sel = |(ing_full & port_mask);
  assign enq      = stream && (|port_mask) && !full_sel;
  assign last     = ((rd_ptr + CW'(1)) == cnt);
  assign start_ok = start && (state == CL_IDLE) && (start_count != '0) && (start_count <= wr_ptr);

  // rst_done keeps load_ready low while reset is held and until the first edge after release.
  assign load_ready = rst_done && (state == CL_IDLE) && (wr_ptr < CW'(DEPTH)) && !clear;
  assign wr_en      = load_valid && load_ready;

  assign ing_enq   = enq ? port_mask : '0;
  assign ing_wdata = stream ? rd_pkt : '0;
  assign busy      = (state != CL_IDLE);
  assign done      = (state == CL_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CL_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      port_q   <= '0;
      err      <= 1'b0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      err      <= 1'b0;
      case (state)
        CL_IDLE: begin
          if (clear)      wr_ptr <= '0;
          else if (wr_en) wr_ptr <= wr_ptr + CW'(1);
          if (start_ok) begin
            port_q <= start_port;
            cnt    <= start_count;
            rd_ptr <= '0;
            state  <= CL_STREAM;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        CL_STREAM: begin
          if (enq) begin
            rd_ptr <= rd_ptr + CW'(1);
            if (last) state <= CL_DONE;
          end
        end
        CL_DONE: state <= CL_IDLE;
        default: state <= CL_IDLE;
      endcase
    end
  end

  cfg_loader_buf #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (load_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_pkt)
  );

`ifdef CFG_LOADER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         stall_cycles <= '0;
    else if (start_ok)                                  stall_cycles <= '0;
    else if (stream && full_sel && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: load, stream, stall, reject, reset-abort and replay cases.
module tb_cfg_stream_loader;
  import pe_types::*;

  localparam int DEPTH = 64;
  localparam int SIDES = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             load_valid = 1'b0;
  packet_t          load_data = '0;
  logic             load_ready;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       start_port = '0;
  logic [CW-1:0]    start_count = '0;
  logic [SIDES-1:0] ing_enq;
  packet_t          ing_wdata;
  logic [SIDES-1:0] ing_full = '0;
  logic             busy, done, err;
`ifdef CFG_LOADER_PERF_EN
  logic [15:0]      stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  cfg_stream_loader #(.DEPTH(DEPTH), .SIDES(SIDES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .clear       (clear),
    .start       (start),
    .start_port  (start_port),
    .start_count (start_count),
    .ing_enq     (ing_enq),
    .ing_wdata   (ing_wdata),
    .ing_full    (ing_full),
    .busy        (busy),
    .done        (done),
    .err         (err)
`ifdef CFG_LOADER_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  function automatic packet_t pkt(input int idx, input int seed);
    packet_t p;
    p.addr = 8'(idx);
    p.data = 24'(seed * 65536 + idx * 3 + 1);
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_n(input int base, input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = pkt(base + i, seed);
      #1;
      check("load_ready_while_loading", 64'(load_ready), 64'(1));
      step();
    end
    load_valid = 1'b0;
  endtask

  task automatic start_stream(input int port, input int count);
    start       = 1'b1;
    start_port  = 3'(port);
    start_count = CW'(count);
    step();
    start = 1'b0;
  endtask

  // Cycles stall_lo..stall_hi (1-based, from first STREAM cycle) hold the target port full;
  // on cycle poke a start and a clear are driven, both of which must be ignored.
  task automatic expect_stream(input int port, input int count, input int seed,
                               input int stall_lo, input int stall_hi, input int poke);
    int got = 0;
    int cyc = 1;
    while (got < count && cyc <= count + 8) begin
      ing_full    = (cyc >= stall_lo && cyc <= stall_hi) ? (8'(1) << port) : 8'd0;
      start       = (cyc == poke);
      clear       = (cyc == poke);
      start_port  = 3'(SR);
      start_count = CW'(1);
      #1;
      check("stream_busy", 64'(busy), 64'(1));
      check("stream_done_low", 64'(done), 64'(0));
      check("stream_err_low", 64'(err), 64'(0));
      check("stream_load_ready_low", 64'(load_ready), 64'(0));
      check("stream_wdata", 64'(ing_wdata), 64'(pkt(got, seed)));
      if (ing_full[port]) begin
        check("stream_enq_stalled", 64'(ing_enq), 64'(0));
      end else begin
        check("stream_enq", 64'(ing_enq), 64'(1) << port);
        got++;
      end
      step();
      cyc++;
    end
    ing_full = '0;
    start    = 1'b0;
    clear    = 1'b0;
    #1;
    check("stream_len", 64'(got), 64'(count));
    check("done_pulse", 64'(done), 64'(1));
    check("done_busy", 64'(busy), 64'(1));
    check("done_enq_low", 64'(ing_enq), 64'(0));
    check("done_wdata_zero", 64'(ing_wdata), 64'(0));
    step();
    check("after_done_low", 64'(done), 64'(0));
    check("after_done_idle", 64'(busy), 64'(0));
  endtask

  task automatic expect_reject(input int count);
    start       = 1'b1;
    start_port  = 3'(WR);
    start_count = CW'(count);
    #1;
    check("reject_enq_same_cycle", 64'(ing_enq), 64'(0));
    step();
    start = 1'b0;
    #1;
    check("reject_err", 64'(err), 64'(1));
    check("reject_busy", 64'(busy), 64'(0));
    check("reject_enq", 64'(ing_enq), 64'(0));
    step();
    check("reject_err_one_cycle", 64'(err), 64'(0));
    check("reject_busy_after", 64'(busy), 64'(0));
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_load_ready", 64'(load_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_enq", 64'(ing_enq), 64'(0));
    check("rst_wdata", 64'(ing_wdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_load_ready", 64'(load_ready), 64'(0));
    step();
    check("post_rst_load_ready", 64'(load_ready), 64'(1));

    // 56 packets streamed to WR at full throughput
    load_n(0, 56, 1);
    start_stream(WR, 56);
    expect_stream(WR, 56, 1, 1000, 0, 0);

    // Replay to NR while poking start and clear mid-stream
    start_stream(NR, 56);
    expect_stream(NR, 56, 1, 1000, 0, 5);

    // Fill to DEPTH; the 65th offer must not be written
    load_n(56, 8, 1);
    load_valid = 1'b1;
    load_data  = pkt(99, 7);
    #1;
    check("full_load_ready", 64'(load_ready), 64'(0));
    step();
    load_valid = 1'b0;
    start_stream(EL, 64);
    expect_stream(EL, 64, 1, 1000, 0, 0);

    // Clear beats a same-cycle load
    clear      = 1'b1;
    load_valid = 1'b1;
    load_data  = pkt(77, 9);
    #1;
    check("clear_blocks_load", 64'(load_ready), 64'(0));
    step();
    clear      = 1'b0;
    load_valid = 1'b0;

    // 4 packets to SL with the port full on cycles 2-4
    load_n(0, 4, 2);
    start_stream(SL, 4);
    expect_stream(SL, 4, 2, 2, 4, 0);
`ifdef CFG_LOADER_PERF_EN
    check("stall_cycles", 64'(stall_cycles), 64'(3));
`endif

    // wr_ptr = 10: count 11 and count 0 rejected, count 10 accepted
    load_n(4, 6, 2);
    expect_reject(11);
    expect_reject(0);
    start_stream(WL, 10);
    expect_stream(WL, 10, 2, 1000, 0, 0);

    // Reset after 5 of 20 packets aborts the stream
    load_n(10, 10, 2);
    start_stream(ER, 20);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("pre_abort_enq", 64'(ing_enq), 64'(1) << ER);
      check("pre_abort_wdata", 64'(ing_wdata), 64'(pkt(k, 2)));
      step();
    end
    rst_n = 1'b0;
    #1;
    check("abort_enq", 64'(ing_enq), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_wdata", 64'(ing_wdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("abort_idle_ready", 64'(load_ready), 64'(1));
    expect_reject(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
